// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main controller.
// The per-state control word lives here so the top only sequences states.
package mips_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_RTYPE  = 2'b01,
        OP_ITYPE  = 2'b10,
        OP_BRANCH = 2'b11
    } alu_op_t;

    typedef enum logic [4:0] {
        S_IDLE, S_FETCH, S_FETCH_WAIT, S_DECODE,
        S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_MEM_RD_WAIT, S_MEM_WB, S_MEM_WR,
        S_BRANCH, S_JUMP, S_JAL, S_JR, S_HALT
    } state_t;

    localparam logic [5:0] OPC_RTYPE  = 6'h00;
    localparam logic [5:0] OPC_REGIMM = 6'h01;
    localparam logic [5:0] OPC_J      = 6'h02;
    localparam logic [5:0] OPC_JAL    = 6'h03;
    localparam logic [5:0] OPC_BEQ    = 6'h04;
    localparam logic [5:0] OPC_BNE    = 6'h05;
    localparam logic [5:0] OPC_BLEZ   = 6'h06;
    localparam logic [5:0] OPC_BGTZ   = 6'h07;
    localparam logic [5:0] OPC_ADDIU  = 6'h09;
    localparam logic [5:0] OPC_SLTI   = 6'h0A;
    localparam logic [5:0] OPC_SLTIU  = 6'h0B;
    localparam logic [5:0] OPC_ANDI   = 6'h0C;
    localparam logic [5:0] OPC_ORI    = 6'h0D;
    localparam logic [5:0] OPC_XORI   = 6'h0E;
    localparam logic [5:0] OPC_IMM_10 = 6'h10;
    localparam logic [5:0] OPC_LW     = 6'h23;
    localparam logic [5:0] OPC_SW     = 6'h2B;
    localparam logic [5:0] OPC_HALT   = 6'h3F;

    localparam logic [5:0] FUNCT_JR   = 6'h08;

    localparam logic [1:0] SRC_B_REGB    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       jump_and_link;
        logic       is_signed;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
        logic [1:0] pc_source;
        logic       halted;
    } ctrl_t;

    function automatic logic itype_signed(input logic [5:0] opc);
        return (opc == OPC_ADDIU) || (opc == OPC_IMM_10) ||
               (opc == OPC_SLTI)  || (opc == OPC_SLTIU);
    endfunction

    // Control word a state presents; opc only matters for EXEC_I sign extension.
    function automatic ctrl_t ctrl_for_state(input state_t s, input logic [5:0] opc);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRC_B_FOUR;
                c.alu_op    = OP_ADD;
                c.pc_source = PC_SRC_ALU;
                c.pc_write  = 1'b1;
            end
            S_FETCH_WAIT: c.ir_write = 1'b1;
            S_DECODE: begin
                c.alu_src_b = SRC_B_IMM_SH2;
                c.is_signed = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = OP_RTYPE;
            end
            S_WB_R: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = OP_ITYPE;
                c.is_signed = itype_signed(opc);
            end
            S_WB_I: c.reg_write = 1'b1;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.is_signed = 1'b1;
            end
            S_MEM_RD: begin
                c.ior_d    = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                c.ior_d     = 1'b1;
                c.mem_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = OP_BRANCH;
                c.pc_source     = PC_SRC_ALUOUT;
                c.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                c.pc_source = PC_SRC_JUMP;
                c.pc_write  = 1'b1;
            end
            S_JAL: begin
                c.pc_source     = PC_SRC_JUMP;
                c.pc_write      = 1'b1;
                c.jump_and_link = 1'b1;
                c.reg_write     = 1'b1;
            end
            S_JR: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = OP_RTYPE;
                c.pc_write  = 1'b1;
            end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_ctrl_fsm_if.sv
// IR fields into the controller and datapath control strobes out of it.
interface mips_ctrl_fsm_if;
    logic [5:0]                  ir_opcode;
    logic [5:0]                  ir_funct;
    logic [4:0]                  ir_rt;
    logic                        pc_write;
    logic                        pc_write_cond;
    logic                        ior_d;
    logic                        mem_read;
    logic                        mem_write;
    logic                        ir_write;
    logic                        mem_to_reg;
    logic                        reg_dst;
    logic                        reg_write;
    logic                        jump_and_link;
    logic                        is_signed;
    logic                        alu_src_a;
    logic [1:0]                  alu_src_b;
    mips_ctrl_pkg::alu_op_t      alu_op;
    logic [1:0]                  pc_source;
    logic                        halted;

    modport master (
        input  ir_opcode, ir_funct, ir_rt,
        output pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, jump_and_link, is_signed,
               alu_src_a, alu_src_b, alu_op, pc_source, halted
    );

    modport slave (
        output ir_opcode, ir_funct, ir_rt,
        input  pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, jump_and_link, is_signed,
               alu_src_a, alu_src_b, alu_op, pc_source, halted
    );
endinterface

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS main controller: Moore FSM whose control word is flopped
// from the next state, so each state's outputs appear in that state's cycle.
module mips_ctrl_fsm
    import mips_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    mips_ctrl_fsm_if.master  bus
);

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= w_ctrl;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       w_next = S_FETCH;
            S_FETCH:      w_next = S_FETCH_WAIT;
            S_FETCH_WAIT: w_next = S_DECODE;
            S_DECODE: begin
                case (bus.ir_opcode)
                    OPC_RTYPE:  w_next = (bus.ir_funct == FUNCT_JR) ? S_JR : S_EXEC_R;
                    OPC_LW, OPC_SW: w_next = S_MEM_ADDR;
                    OPC_ADDIU, OPC_IMM_10, OPC_SLTI, OPC_SLTIU,
                    OPC_ANDI, OPC_ORI, OPC_XORI: w_next = S_EXEC_I;
                    OPC_BEQ, OPC_BNE, OPC_BLEZ, OPC_BGTZ,
                    OPC_REGIMM: w_next = S_BRANCH;
                    OPC_J:      w_next = S_JUMP;
                    OPC_JAL:    w_next = S_JAL;
                    OPC_HALT:   w_next = S_HALT;
                    // Unknown opcodes retire as a NOP straight back to fetch.
                    default:    w_next = S_FETCH;
                endcase
            end
            S_EXEC_R:      w_next = S_WB_R;
            S_WB_R:        w_next = S_FETCH;
            S_EXEC_I:      w_next = S_WB_I;
            S_WB_I:        w_next = S_FETCH;
            S_MEM_ADDR:    w_next = (bus.ir_opcode == OPC_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:      w_next = S_MEM_RD_WAIT;
            S_MEM_RD_WAIT: w_next = S_MEM_WB;
            S_MEM_WB:      w_next = S_FETCH;
            S_MEM_WR:      w_next = S_FETCH;
            S_BRANCH:      w_next = S_FETCH;
            S_JUMP:        w_next = S_FETCH;
            S_JAL:         w_next = S_FETCH;
            S_JR:          w_next = S_FETCH;
            S_HALT:        w_next = S_HALT;
            default:       w_next = S_IDLE;
        endcase
        w_ctrl = ctrl_for_state(w_next, bus.ir_opcode);
    end

    assign bus.pc_write      = r_ctrl.pc_write;
    assign bus.pc_write_cond = r_ctrl.pc_write_cond;
    assign bus.ior_d         = r_ctrl.ior_d;
    assign bus.mem_read      = r_ctrl.mem_read;
    assign bus.mem_write     = r_ctrl.mem_write;
    assign bus.ir_write      = r_ctrl.ir_write;
    assign bus.mem_to_reg    = r_ctrl.mem_to_reg;
    assign bus.reg_dst       = r_ctrl.reg_dst;
    assign bus.reg_write     = r_ctrl.reg_write;
    assign bus.jump_and_link = r_ctrl.jump_and_link;
    assign bus.is_signed     = r_ctrl.is_signed;
    assign bus.alu_src_a     = r_ctrl.alu_src_a;
    assign bus.alu_src_b     = r_ctrl.alu_src_b;
    assign bus.alu_op        = r_ctrl.alu_op;
    assign bus.pc_source     = r_ctrl.pc_source;
    assign bus.halted        = r_ctrl.halted;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Bench for mips_ctrl_fsm: per-instruction expected control sequences built
// from the instruction class, compared cycle by cycle against the DUT.
module tb_mips_ctrl_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       jal;
        logic       is_signed;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       halted;
    } ctl_t;

    localparam logic [1:0] A_ADD = 2'd0, A_RTYPE = 2'd1, A_ITYPE = 2'd2, A_BRANCH = 2'd3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    ctl_t exp_q[$];

    always #5 clk = ~clk;

    mips_ctrl_fsm_if u_if();

    mips_ctrl_fsm u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
        end
    endtask

    function automatic ctl_t observed();
        ctl_t o;
        o.pc_write      = u_if.pc_write;
        o.pc_write_cond = u_if.pc_write_cond;
        o.ior_d         = u_if.ior_d;
        o.mem_read      = u_if.mem_read;
        o.mem_write     = u_if.mem_write;
        o.ir_write      = u_if.ir_write;
        o.mem_to_reg    = u_if.mem_to_reg;
        o.reg_dst       = u_if.reg_dst;
        o.reg_write     = u_if.reg_write;
        o.jal           = u_if.jump_and_link;
        o.is_signed     = u_if.is_signed;
        o.src_a         = u_if.alu_src_a;
        o.src_b         = u_if.alu_src_b;
        o.alu_op        = u_if.alu_op;
        o.pc_src        = u_if.pc_source;
        o.halted        = u_if.halted;
        return o;
    endfunction

    // Reference: expected control word for every cycle from FETCH to retirement.
    task automatic build(input logic [5:0] opc, input logic [5:0] funct, input int halt_n);
        ctl_t c;
        c = '0; c.mem_read = 1; c.src_b = 2'b01; c.alu_op = A_ADD; c.pc_write = 1; exp_q.push_back(c);
        c = '0; c.ir_write = 1; exp_q.push_back(c);
        c = '0; c.src_b = 2'b11; c.is_signed = 1; exp_q.push_back(c);
        if (opc == 6'h00 && funct == 6'h08) begin
            c = '0; c.src_a = 1; c.alu_op = A_RTYPE; c.pc_src = 2'b00; c.pc_write = 1; exp_q.push_back(c);
        end else if (opc == 6'h00) begin
            c = '0; c.src_a = 1; c.src_b = 2'b00; c.alu_op = A_RTYPE; exp_q.push_back(c);
            c = '0; c.reg_dst = 1; c.reg_write = 1; exp_q.push_back(c);
        end else if (opc == 6'h23 || opc == 6'h2B) begin
            c = '0; c.src_a = 1; c.src_b = 2'b10; c.is_signed = 1; exp_q.push_back(c);
            if (opc == 6'h23) begin
                c = '0; c.ior_d = 1; c.mem_read = 1; exp_q.push_back(c);
                c = '0; exp_q.push_back(c);
                c = '0; c.mem_to_reg = 1; c.reg_write = 1; exp_q.push_back(c);
            end else begin
                c = '0; c.ior_d = 1; c.mem_write = 1; exp_q.push_back(c);
            end
        end else if (opc inside {6'h09, 6'h10, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E}) begin
            c = '0; c.src_a = 1; c.src_b = 2'b10; c.alu_op = A_ITYPE;
            c.is_signed = (opc inside {6'h09, 6'h10, 6'h0A, 6'h0B});
            exp_q.push_back(c);
            c = '0; c.reg_write = 1; exp_q.push_back(c);
        end else if (opc inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07}) begin
            c = '0; c.src_a = 1; c.alu_op = A_BRANCH; c.pc_src = 2'b01; c.pc_write_cond = 1; exp_q.push_back(c);
        end else if (opc == 6'h02) begin
            c = '0; c.pc_src = 2'b10; c.pc_write = 1; exp_q.push_back(c);
        end else if (opc == 6'h03) begin
            c = '0; c.pc_src = 2'b10; c.pc_write = 1; c.jal = 1; c.reg_write = 1; exp_q.push_back(c);
        end else if (opc == 6'h3F) begin
            c = '0; c.halted = 1;
            for (int i = 0; i < halt_n; i++) exp_q.push_back(c);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("reset#%0d", i), 32'(observed()), 32'd0);
        end
        rst_n = 1'b1;
    endtask

    // The IR only holds the real instruction during DECODE and MEM_ADDR;
    // every other cycle sees random junk that must be ignored.
    task automatic run_instr(input logic [5:0] opc, input logic [5:0] funct, input logic [4:0] rt,
                             input string tag, input int halt_n, input int abort_at);
        ctl_t e;
        int   idx;
        build(opc, funct, halt_n);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("%s#%0d", tag, idx), 32'(observed()), 32'(e));
            if (idx == abort_at) begin
                exp_q.delete();
                return;
            end
            if (idx == 2 || idx == 3) begin
                u_if.ir_opcode = opc;
                u_if.ir_funct  = funct;
                u_if.ir_rt     = rt;
            end else begin
                u_if.ir_opcode = 6'($urandom);
                u_if.ir_funct  = 6'($urandom);
                u_if.ir_rt     = 5'($urandom);
            end
            idx++;
        end
    endtask

    logic [5:0] legal_ops [14] = '{6'h00, 6'h23, 6'h2B, 6'h09, 6'h10, 6'h0A, 6'h0B,
                                   6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h01, 6'h02, 6'h03};

    initial begin
        logic [5:0] opc;
        logic [5:0] fn;
        rst_n = 1'b0;
        u_if.ir_opcode = 6'h3F;
        u_if.ir_funct  = 6'h00;
        u_if.ir_rt     = 5'h00;
        do_reset(3);

        run_instr(6'h00, 6'h21, 5'd0, "addu",  0, -1);
        run_instr(6'h23, 6'h00, 5'd0, "lw",    0, -1);
        run_instr(6'h2B, 6'h00, 5'd0, "sw",    0, -1);
        run_instr(6'h04, 6'h00, 5'd0, "beq",   0, -1);
        run_instr(6'h01, 6'h00, 5'd0, "bltz",  0, -1);
        run_instr(6'h01, 6'h00, 5'd1, "bgez",  0, -1);
        run_instr(6'h03, 6'h00, 5'd0, "jal",   0, -1);
        run_instr(6'h00, 6'h08, 5'd0, "jr",    0, -1);
        run_instr(6'h02, 6'h00, 5'd0, "j",     0, -1);
        run_instr(6'h3E, 6'h00, 5'd0, "illeg", 0, -1);
        run_instr(6'h09, 6'h00, 5'd0, "addiu", 0, -1);
        run_instr(6'h0D, 6'h00, 5'd0, "ori",   0, -1);
        run_instr(6'h10, 6'h00, 5'd0, "op10",  0, -1);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 7) opc = legal_ops[$urandom_range(0, 13)];
            else opc = 6'($urandom_range(0, 62));
            fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            run_instr(opc, fn, 5'($urandom_range(0, 1)), $sformatf("rnd%0d_op%02h", n, opc), 0, -1);
        end

        run_instr(6'h23, 6'h00, 5'd0, "lw_abort", 0, 4);
        do_reset(2);
        run_instr(6'h00, 6'h21, 5'd0, "post_abort", 0, -1);

        run_instr(6'h3F, 6'h00, 5'd0, "halt", 20, -1);
        do_reset(2);
        run_instr(6'h00, 6'h21, 5'd0, "post_halt", 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
